// File: rtl/cb_config_sequencer.sv
// Connection-box configuration sequencer: one outstanding host request,
// timed config-bus write/readback, verify compare and mismatch counter.
module cb_config_sequencer #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ERR_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_op,
  input  logic                  req_verify,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_error,
  output logic [ADDR_WIDTH-1:0] config_addr,
  output logic [DATA_WIDTH-1:0] config_data,
  output logic                  config_en,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic [ERR_WIDTH-1:0]  err_count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    SETTLE,
    RESP
  } state_t;

  state_t state, state_nxt;
  logic   op_q;
  logic   verify_q;
  logic   accept;
  logic   mismatch;

  // ready is gated by reset so nothing is accepted on a reset edge
  assign req_ready = (state == IDLE) & reset;
  assign accept    = req_valid & req_ready;
  assign config_en = (state == WRITE);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // config_data still holds the written value during SETTLE
  assign mismatch = ~op_q & verify_q & (read_data != config_data);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = req_op ? SETTLE : WRITE;
      WRITE:   state_nxt = SETTLE;
      SETTLE:  state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      op_q        <= 1'b0;
      verify_q    <= 1'b0;
      config_addr <= '0;
      config_data <= '0;
      rsp_data    <= '0;
      rsp_error   <= 1'b0;
      err_count   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        config_addr <= req_addr;
        config_data <= req_data;
        op_q        <= req_op;
        verify_q    <= req_verify;
      end
      if (state == SETTLE) begin
        rsp_data  <= read_data;
        rsp_error <= mismatch;
        if (mismatch && (err_count != '1))
          err_count <= err_count + ERR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_cb_config_sequencer.sv
// Self-checking bench for cb_config_sequencer with a small register-file
// target and a transaction-level reference model.
module tb_cb_config_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_op;
  logic        req_verify;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic [31:0] config_addr;
  logic [31:0] config_data;
  logic        config_en;
  logic [31:0] read_data;
  logic [7:0]  err_count;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          err_model = 0;
  bit          mism = 1'b0;

  always #5 clk = ~clk;

  cb_config_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_verify (req_verify),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_error  (rsp_error),
    .config_addr(config_addr),
    .config_data(config_data),
    .config_en  (config_en),
    .read_data  (read_data),
    .err_count  (err_count),
    .busy       (busy)
  );

  // target: latches on config_en, mism flips bit 0 of the readback
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (config_en) begin
      mem[config_addr[3:0]] <= config_data;
    end
  end

  assign read_data = mem[config_addr[3:0]] ^ {31'b0, mism};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    err_model = 0;
  endtask

  task automatic txn(input bit op, input bit vfy, input logic [3:0] a,
                     input logic [31:0] d, input bit cor, input int stall);
    int          lat;
    int          en_cnt;
    logic [31:0] exp_d;
    bit          exp_e;
    logic [31:0] held;
    exp_e = !op && vfy && cor;
    exp_d = (op ? ref_mem[a] : d) ^ {31'b0, cor};
    @(negedge clk);
    req_valid  = 1'b1;
    req_op     = op;
    req_verify = vfy;
    req_addr   = {28'b0, a};
    req_data   = d;
    mism       = cor;
    rsp_ready  = (stall == 0);
    chk("req_ready_idle", req_ready, 1);
    lat = 0;
    en_cnt = 0;
    do begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      if (config_en) en_cnt++;
    end while (!rsp_valid && lat < 20);
    chk("rsp_latency", lat, op ? 2 : 3);
    chk("config_en_pulses", en_cnt, op ? 0 : 1);
    chk("config_addr", config_addr, {28'b0, a});
    if (!op) ref_mem[a] = d;
    if (exp_e) err_model = (err_model == 255) ? 255 : err_model + 1;
    chk("rsp_data", rsp_data, exp_d);
    chk("rsp_error", rsp_error, exp_e);
    chk("err_count", err_count, err_model);
    held = rsp_data;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_data", rsp_data, held);
      chk("stall_ready", req_ready, 0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("done_valid", rsp_valid, 0);
    chk("done_busy", busy, 0);
    chk("done_ready", req_ready, 1);
    mism = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_op     = 1'b0;
    req_verify = 1'b0;
    req_addr   = '0;
    req_data   = '0;
    rsp_ready  = 1'b1;
    clear_ref();
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_config_en", config_en, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_config_addr", config_addr, 0);
    chk("rst_config_data", config_data, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_error", rsp_error, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);

    txn(1'b0, 1'b1, 4'd0, 32'h1, 1'b0, 0);
    txn(1'b0, 1'b1, 4'd0, 32'h7A, 1'b0, 0);
    chk("tgt_const", mem[0][19:4], 16'd7);
    chk("tgt_sel", mem[0][3:0], 4'd10);
    txn(1'b0, 1'b1, 4'd0, 32'h8, 1'b1, 0);
    txn(1'b0, 1'b0, 4'd0, 32'h8, 1'b1, 0);
    txn(1'b1, 1'b0, 4'd0, 32'h0, 1'b0, 0);
    txn(1'b1, 1'b1, 4'd0, 32'h0, 1'b0, 5);

    // reset while the write strobe is high
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 1'b0;
    req_addr  = 32'h3;
    req_data  = 32'hDEAD;
    @(negedge clk);
    req_valid = 1'b0;
    chk("wr_strobe", config_en, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("rstw_config_en", config_en, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_rsp_valid", rsp_valid, 0);
    chk("rstw_err_count", err_count, 0);
    reset = 1'b1;
    clear_ref();
    @(negedge clk);
    chk("rstw_ready", req_ready, 1);

    for (int n = 0; n < 40; n++) begin
      txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          4'($urandom_range(0, 15)), $urandom,
          1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    for (int n = 0; n < 260; n++) begin
      txn(1'b0, 1'b1, 4'($urandom_range(0, 15)), $urandom, 1'b1, 0);
    end
    chk("sat_final", err_count, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
